// File: rtl/sram_job_sequencer.sv
// sram_job_sequencer
//   Initiator for sram_controller. Accepts host jobs (write rows, read rows,
//   IMC vectors) and drives the controller's request pins. It holds the
//   controller in reset through its active-low reset whenever no job is
//   running. It counts job completions from the controller's Increment*
//   pulses and owns the weight/input/SA/output buffer address counters.
//
//   Optional feature: define SRAM_SEQ_WDOG_EN to build a per-operation
//   watchdog. While in RUN, a cycle counter is cleared by every completion
//   event. If TIMEOUT cycles pass with no event, the job is aborted and the
//   sticky err flag is set. Without the macro, err is tied low and TIMEOUT
//   has no effect.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     job handshake; cmd_ready is high only in IDLE
//   cmd_op                  00 write, 01 read, 10 IMC, 11 reserved
//   cmd_base, cmd_count     first row address, number of operations
//   done                    1-cycle pulse at job end
//   err                     sticky watchdog error (cleared by next started job)
//   ctrl_reset_n            controller reset (0 = controller held in reset)
//   rw, imc_en, mem_en,
//   en_dec, address_input   controller request pins
//   halt                    controller busy (status only, not used here)
//   Increment*              controller progress pulses (rising-edge detected)
//   wt/ib/sa/ob_addr        buffer address counters, wrap at 2**BUF_AW
module sram_job_sequencer #(
  parameter int CNT_W   = 5,
  parameter int BUF_AW  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_base,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              done,
  output logic              err,
  output logic              ctrl_reset_n,
  output logic              rw,
  output logic              imc_en,
  output logic              mem_en,
  output logic              en_dec,
  output logic [3:0]        address_input,
  input  logic              halt,
  input  logic              IncrementWtAddr,
  input  logic              IncrementInbuffAddr,
  input  logic              IncrementSAbuffAddr,
  input  logic              IncrementOBbuffAddr,
  output logic [BUF_AW-1:0] wt_addr,
  output logic [BUF_AW-1:0] ib_addr,
  output logic [BUF_AW-1:0] sa_addr,
  output logic [BUF_AW-1:0] ob_addr
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_IMC   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [CNT_W-1:0] remaining_reg;

  // Increment inputs packed as [0]=Wt, [1]=Inbuff, [2]=SAbuff, [3]=OBbuff.
  logic [3:0] inc_in;
  logic [3:0] inc_q_reg;
  logic [3:0] inc_rise;
  logic [3:0] cnt_step;
  logic       complete_event;
  logic       imc_event;
  logic       wd_expire;

  assign inc_in = {IncrementOBbuffAddr, IncrementSAbuffAddr,
                   IncrementInbuffAddr, IncrementWtAddr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inc_q_reg <= '0;
    else       inc_q_reg <= inc_in;
  end

  // The controller can hold IncrementWtAddr high through a whole IMC job,
  // so only rising edges count as progress.
  assign inc_rise = inc_in & ~inc_q_reg;

  always_comb begin
    complete_event = 1'b0;
    if (state_reg == RUN) begin
      case (op_reg)
        OP_WRITE: complete_event = inc_rise[0];
        OP_READ:  complete_event = inc_rise[2];
        OP_IMC:   complete_event = inc_rise[3];
        default:  complete_event = 1'b0;
      endcase
    end
  end

  assign imc_event = complete_event && (op_reg == OP_IMC);

  // An IMC vector completion also consumes one input-buffer entry. If it
  // coincides with an Inbuff rise, the counter still advances by only one.
  assign cnt_step = {inc_rise[3], inc_rise[2], inc_rise[1] | imc_event, inc_rise[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_buf_cnt
      logic [BUF_AW-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)             cnt_reg <= '0;
        else if (cnt_step[gi]) cnt_reg <= cnt_reg + BUF_AW'(1);
      end
    end
  endgenerate

  assign wt_addr = g_buf_cnt[0].cnt_reg;
  assign ib_addr = g_buf_cnt[1].cnt_reg;
  assign sa_addr = g_buf_cnt[2].cnt_reg;
  assign ob_addr = g_buf_cnt[3].cnt_reg;

  assign cmd_ready = (state_reg == IDLE);

`ifdef SRAM_SEQ_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            err_reg;

  // Fires on the TIMEOUT-th consecutive RUN cycle without a completion.
  assign wd_expire = (state_reg == RUN) && !complete_event &&
                     (wd_cnt_reg == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_reg != RUN || complete_event) wd_cnt_reg <= '0;
      else                                    wd_cnt_reg <= wd_cnt_reg + WD_W'(1);

      // err survives until a job that actually starts the controller.
      if (state_reg == IDLE && cmd_valid && cmd_count != '0 && cmd_op != OP_RSVD)
        err_reg <= 1'b0;
      else if (wd_expire)
        err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // halt is status only; TIMEOUT matters only with the watchdog built in.
  logic unused_sig;
  assign unused_sig = &{1'b0, halt, (TIMEOUT > 0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_reg        <= OP_WRITE;
      remaining_reg <= '0;
      ctrl_reset_n  <= 1'b0;
      rw            <= 1'b1;
      imc_en        <= 1'b0;
      mem_en        <= 1'b0;
      en_dec        <= 1'b0;
      address_input <= 4'd0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            op_reg        <= cmd_op;
            remaining_reg <= cmd_count;
            if (cmd_count == '0 || cmd_op == OP_RSVD) begin
              // Nothing to do: finish without releasing the controller.
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              rw            <= (cmd_op == OP_READ);
              imc_en        <= (cmd_op == OP_IMC);
              mem_en        <= (cmd_op != OP_IMC);
              en_dec        <= 1'b1;
              address_input <= cmd_base;
              state_reg     <= SETUP;
            end
          end
        end

        SETUP: begin
          // Request pins have been stable for one cycle under reset.
          ctrl_reset_n <= 1'b1;
          state_reg    <= RUN;
        end

        RUN: begin
          if (complete_event) begin
            remaining_reg <= remaining_reg - CNT_W'(1);
            address_input <= address_input + 4'd1;
            if (remaining_reg == CNT_W'(1)) begin
              // Park the controller as it returns to idle after the last op.
              ctrl_reset_n <= 1'b0;
              state_reg    <= DONE;
              done         <= 1'b1;
            end
          end else if (wd_expire) begin
            ctrl_reset_n <= 1'b0;
            state_reg    <= DONE;
            done         <= 1'b1;
          end
        end

        DONE: begin
          imc_en    <= 1'b0;
          mem_en    <= 1'b0;
          en_dec    <= 1'b0;
          rw        <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
